// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Load misses refill the whole line from main memory; stores always go to memory.
module dcache_controller #(
    parameter int INDEX_BITS  = 6,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [LINES-1:0]      r_valid;
    logic [TAG_W-1:0]      r_tag  [LINES];
    logic [31:0]           r_data [LINES][4];
    logic [27:0]           r_base;
    logic [1:0]            r_cnt;
    logic [31:0]           r_wAddr;
    logic [31:0]           r_wData;
    logic [31:0]           r_hits;
    logic [31:0]           r_misses;

    logic [INDEX_BITS-1:0] w_index;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_off;
    logic                  w_hit;
    logic [INDEX_BITS-1:0] w_fillIndex;
    logic [TAG_W-1:0]      w_fillTag;
    logic [INDEX_BITS-1:0] w_wIndex;
    logic [TAG_W-1:0]      w_wTag;
    logic [1:0]            w_wOff;
    logic                  w_loadHit;
    logic                  w_loadMiss;
    logic                  w_fillWord;
    logic                  w_fillDone;
    logic                  w_storeUpdate;
    logic                  w_unused;

    assign w_index       = cpu_addr[INDEX_BITS+3:4];
    assign w_tag         = cpu_addr[31:INDEX_BITS+4];
    assign w_off         = cpu_addr[3:2];
    assign w_hit         = r_valid[w_index] && (r_tag[w_index] == w_tag);
    assign w_fillIndex   = r_base[INDEX_BITS-1:0];
    assign w_fillTag     = r_base[27:INDEX_BITS];
    assign w_wIndex      = r_wAddr[INDEX_BITS+3:4];
    assign w_wTag        = r_wAddr[31:INDEX_BITS+4];
    assign w_wOff        = r_wAddr[3:2];
    assign w_loadHit     = (r_state == IDLE) && cpu_rd && !cpu_wr && w_hit;
    assign w_loadMiss    = (r_state == IDLE) && cpu_rd && !cpu_wr && !w_hit;
    assign w_fillWord    = (r_state == REFILL) && mem_ready;
    assign w_fillDone    = w_fillWord && (r_cnt == 2'd3);
    assign w_storeUpdate = (r_state == WRITE) && mem_ready && r_valid[w_wIndex]
                           && (r_tag[w_wIndex] == w_wTag);
    assign w_unused      = (^cpu_addr[1:0]) | (MEM_TIMEOUT != 0);

    assign hit_count  = r_hits;
    assign miss_count = r_misses;

    always_comb begin
        w_next    = r_state;
        cpu_stall = 1'b0;
        cpu_rdata = 32'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        unique case (r_state)
            IDLE: begin
                if (cpu_wr) begin
                    cpu_stall = 1'b1;
                    w_next    = WRITE;
                end else if (cpu_rd) begin
                    if (w_hit) begin
                        cpu_rdata = r_data[w_index][w_off];
                    end else begin
                        cpu_stall = 1'b1;
                        w_next    = REFILL;
                    end
                end
            end
            REFILL: begin
                mem_rd    = 1'b1;
                mem_addr  = {r_base, r_cnt, 2'b00};
                cpu_stall = 1'b1;
                if (w_fillDone) begin
                    w_next = IDLE;
                end
            end
            WRITE: begin
                // The pipeline moves on at the completing edge, so the stall drops with mem_ready.
                mem_wr    = 1'b1;
                mem_addr  = r_wAddr;
                mem_wdata = r_wData;
                cpu_stall = !mem_ready;
                if (mem_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= 2'd0;
            r_valid  <= '0;
            r_hits   <= 32'd0;
            r_misses <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_loadHit) begin
                r_hits <= r_hits + 32'd1;
            end
            if (w_loadMiss) begin
                r_misses <= r_misses + 32'd1;
                r_cnt    <= 2'd0;
            end else if (w_fillWord) begin
                r_cnt <= r_cnt + 2'd1;
            end
            if (w_fillDone) begin
                r_valid[w_fillIndex] <= 1'b1;
            end
        end
    end

    // Storage and request latches need no reset; an aborted refill never sets valid.
    always_ff @(posedge clk) begin
        if (w_loadMiss) begin
            r_base <= cpu_addr[31:4];
        end
        if ((r_state == IDLE) && cpu_wr) begin
            r_wAddr <= {cpu_addr[31:2], 2'b00};
            r_wData <= cpu_wdata;
        end
        if (!reset && w_fillWord) begin
            r_data[w_fillIndex][r_cnt] <= mem_rdata;
        end
        if (!reset && w_fillDone) begin
            r_tag[w_fillIndex] <= w_fillTag;
        end
        if (!reset && w_storeUpdate) begin
            r_data[w_wIndex][w_wOff] <= r_wData;
        end
    end

endmodule
